// File: rtl/serial_deserializer.sv
// Serial-to-parallel byte deserializer with per-frame bit order and a one-byte output holding register.
// Optional even-parity frame bit is compiled in with `define PARITY_CHECK_EN.
module serial_deserializer (
  input  logic       clk,
  input  logic       reset,
  input  logic       sin,
  input  logic       sin_valid,
  input  logic       dir,
  input  logic       o_ready,
  output logic [7:0] o,
  output logic       o_valid,
  output logic       busy,
  output logic       overrun,
  output logic       parity_err
);

  typedef enum logic [1:0] {
    IDLE,
    DATA
`ifdef PARITY_CHECK_EN
    , PARITY
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        dir_q, dir_d;
  logic [7:0]  o_q, o_d;
  logic        o_valid_q, o_valid_d;
  logic        overrun_q, overrun_d;
  logic        dir_sel;
  logic [7:0]  shifted;
  logic        done;
  logic [7:0]  new_byte;
`ifdef PARITY_CHECK_EN
  logic        pe_q, pe_d;
  logic        new_pe;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    dir_d     = dir_q;
    o_d       = o_q;
    o_valid_d = o_valid_q;
    overrun_d = overrun_q;
    done      = 1'b0;
    new_byte  = shift_q;
`ifdef PARITY_CHECK_EN
    pe_d      = pe_q;
    new_pe    = 1'b0;
`endif
    // The first bit of a frame uses the live dir pin; later bits use the latched copy.
    dir_sel = (state_q == IDLE) ? dir : dir_q;
    shifted = dir_sel ? {shift_q[6:0], sin} : {sin, shift_q[7:1]};

    case (state_q)
      IDLE: begin
        if (sin_valid) begin
          dir_d   = dir;
          shift_d = shifted;
          cnt_d   = 3'd1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (sin_valid) begin
          shift_d = shifted;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
`ifdef PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d  = IDLE;
            done     = 1'b1;
            new_byte = shifted;
`endif
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (sin_valid) begin
          state_d  = IDLE;
          done     = 1'b1;
          new_byte = shift_q;
          new_pe   = (^shift_q) ^ sin;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // A completed byte either replaces the held one (free or being consumed) or is dropped.
    if (done) begin
      if (o_valid_q && !o_ready) begin
        overrun_d = 1'b1;
      end else begin
        o_d       = new_byte;
        o_valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
        pe_d      = new_pe;
`endif
      end
    end else if (o_valid_q && o_ready) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      dir_q     <= 1'b0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      pe_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      dir_q     <= dir_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      overrun_q <= overrun_d;
`ifdef PARITY_CHECK_EN
      pe_q      <= pe_d;
`endif
    end
  end

  assign o       = o_q;
  assign o_valid = o_valid_q;
  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;
`ifdef PARITY_CHECK_EN
  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench for serial_deserializer: stimulus queues expected bytes, a monitor checks each handshake.
module tb_serial_deserializer;

`ifdef PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, sin, sin_valid, dir, o_ready;
  logic [7:0] o;
  logic       o_valid, busy, overrun, parity_err;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [8:0] exp_q[$];

  serial_deserializer dut (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .dir(dir),
    .o_ready(o_ready), .o(o), .o_valid(o_valid), .busy(busy),
    .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic send_bit(input logic b);
    sin       = b;
    sin_valid = 1'b1;
    @(posedge clk); #1;
    sin_valid = 1'b0;
  endtask

  task automatic gap_cycles(input int n);
    for (int g = 0; g < n; g++) begin
      chk("gap_busy", {7'b0, busy}, 8'h01);
      chk("gap_no_valid", {7'b0, o_valid}, 8'h00);
      @(posedge clk); #1;
    end
  endtask

  // Sends v in the bit order selected by d; optionally toggles dir mid-frame,
  // raises o_ready for the last bit, and inverts the parity bit.
  task automatic send_frame(input logic [7:0] v, input logic d, input int gap,
                            input logic toggle, input logic ready_last, input logic pflip);
    logic [7:0] s;
    s   = v;
    dir = d;
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && !PAR && ready_last) o_ready = 1'b1;
      send_bit(d ? s[7] : s[0]);
      s = d ? (s << 1) : (s >> 1);
      if (toggle) dir = ~dir;
      if (i < 7 || PAR) gap_cycles(gap);
    end
    if (PAR) begin
      if (ready_last) o_ready = 1'b1;
      send_bit((^v) ^ pflip);
    end
  endtask

  function automatic logic [8:0] expv(input logic [7:0] v, input logic pflip);
    return {PAR ? pflip : 1'b0, v};
  endfunction

  always @(negedge clk) begin
    if (!reset && o_valid && o_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_output: got %h expected none at %0t", o, $time);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("out_byte", o, e[7:0]);
        chk("out_parity_err", {7'b0, parity_err}, {7'b0, e[8]});
      end
    end
  end

  initial begin
    reset = 1'b1; sin = 1'b0; sin_valid = 1'b0; dir = 1'b0; o_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o", o, 8'h00);
    chk("rst_o_valid", {7'b0, o_valid}, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    chk("rst_overrun", {7'b0, overrun}, 8'h00);
    chk("rst_parity_err", {7'b0, parity_err}, 8'h00);
    reset = 1'b0;

    // LSB first, starting on the first edge after reset release
    exp_q.push_back(expv(8'h4D, 1'b0));
    send_frame(8'h4D, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("lsb_o", o, 8'h4D);
    chk("lsb_o_valid", {7'b0, o_valid}, 8'h01);
    chk("lsb_busy_after", {7'b0, busy}, 8'h00);

    // MSB first, back-to-back, dir toggled mid-frame
    exp_q.push_back(expv(8'hB2, 1'b0));
    send_frame(8'hB2, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    chk("msb_toggle_o", o, 8'hB2);
    chk("msb_toggle_o_valid", {7'b0, o_valid}, 8'h01);

    // Gaps of 3 idle cycles between bits
    exp_q.push_back(expv(8'hFF, 1'b0));
    send_frame(8'hFF, 1'b1, 3, 1'b0, 1'b0, 1'b0);
    chk("gap_o", o, 8'hFF);
    chk("gap_o_valid", {7'b0, o_valid}, 8'h01);
    @(posedge clk); #1;

    // Overrun: second frame dropped while the first is held
    o_ready = 1'b0;
    exp_q.push_back(expv(8'h11, 1'b0));
    send_frame(8'h11, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("hold_o", o, 8'h11);
    chk("no_overrun_yet", {7'b0, overrun}, 8'h00);
    send_frame(8'h22, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("ovr_o_kept", o, 8'h11);
    chk("ovr_o_valid", {7'b0, o_valid}, 8'h01);
    chk("ovr_flag", {7'b0, overrun}, 8'h01);
    o_ready = 1'b1;
    @(posedge clk); #1;
    chk("consume_o_valid", {7'b0, o_valid}, 8'h00);
    chk("ovr_sticky", {7'b0, overrun}, 8'h01);

    // Completion coincident with consumption of the held byte
    o_ready = 1'b0;
    exp_q.push_back(expv(8'h22, 1'b0));
    send_frame(8'h22, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(expv(8'h33, 1'b0));
    send_frame(8'h33, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("coincide_o", o, 8'h33);
    chk("coincide_o_valid", {7'b0, o_valid}, 8'h01);
    chk("coincide_overrun", {7'b0, overrun}, 8'h01);
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a frame discards it
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    chk("partial_busy", {7'b0, busy}, 8'h01);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_busy", {7'b0, busy}, 8'h00);
    chk("midrst_o_valid", {7'b0, o_valid}, 8'h00);
    chk("midrst_overrun", {7'b0, overrun}, 8'h00);
    chk("midrst_o", o, 8'h00);
    exp_q.push_back(expv(8'hA5, 1'b0));
    send_frame(8'hA5, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("after_rst_o", o, 8'hA5);
    if (PAR) begin
      exp_q.push_back(expv(8'hA5, 1'b1));
      send_frame(8'hA5, 1'b0, 0, 1'b0, 1'b0, 1'b1);
      chk("bad_parity_err", {7'b0, parity_err}, 8'h01);
    end

    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge clk);
    #1;
    chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
